// File: rtl/buffer_drain_serializer.sv
// -----------------------------------------------------------------------------
// buffer_drain_serializer
//
// Purpose:
//   Read-side consumer of the circular buffer. Pops WIDTH-bit words from the
//   buffer head and streams each one to a narrow sink as NUM_CHUNKS =
//   WIDTH/OUT_WIDTH chunks of OUT_WIDTH bits. When the last chunk of a word is
//   accepted and another word is waiting, the next word is popped on the same
//   edge, so there is no idle cycle between consecutive words.
//
// Build option:
//   SERIAL_MSB_FIRST_EN  defined   -> most-significant chunk first
//                        undefined -> least-significant chunk first (default)
//   Handshake, timing and ultimo_o are identical in both builds.
//
// Ports:
//   clk_i        in   1          clock, rising edge
//   rstn_i       in   1          asynchronous active-low reset
//   vacia_i      in   1          buffer empty flag
//   dato_i       in   WIDTH      buffer head word, valid when vacia_i=0
//   delecion_o   out  1          pop strobe; head word consumed at this edge
//   valid_o      out  1          chunk valid towards the sink
//   dato_o       out  OUT_WIDTH  current chunk (0 when valid_o=0)
//   ready_i      in   1          sink ready
//   ultimo_o     out  1          final chunk of a word (only with valid_o)
//   ocupado_o    out  1          high whenever the FSM is not IDLE
//   dbg_state_o  out  1          FSM state for observation (0=IDLE, 1=SEND)
//
// Handshake (sink side): a chunk transfers on every rising edge where
//   valid_o=1 and ready_i=1. Once valid_o is raised it stays high, and dato_o
//   and ultimo_o stay stable, until that transfer happens. valid_o never
//   depends combinationally on ready_i.
// Handshake (buffer side): delecion_o=1 on a rising edge consumes dato_i.
//   It is only raised while vacia_i=0, once per word.
// -----------------------------------------------------------------------------
module buffer_drain_serializer #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 vacia_i,
  input  logic [WIDTH-1:0]     dato_i,
  output logic                 delecion_o,
  output logic                 valid_o,
  output logic [OUT_WIDTH-1:0] dato_o,
  input  logic                 ready_i,
  output logic                 ultimo_o,
  output logic                 ocupado_o,
  output logic                 dbg_state_o
);

  localparam int NUM_CHUNKS = WIDTH / OUT_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  // A word must split into a whole number of chunks.
  if ((WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
    $error("buffer_drain_serializer: WIDTH must be a multiple of OUT_WIDTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               last_chunk;
  logic               xfer;
  logic               pop;
  logic [OUT_WIDTH-1:0] head_chunk;
  logic [WIDTH-1:0]   shifted;

  // ---------------------------------------------------------------------------
  // Chunk selection and shift direction depend on the build option.
  // ---------------------------------------------------------------------------
`ifdef SERIAL_MSB_FIRST_EN
  assign head_chunk = shift_q[WIDTH-1 -: OUT_WIDTH];
  assign shifted    = shift_q << OUT_WIDTH;
`else
  assign head_chunk = shift_q[OUT_WIDTH-1:0];
  assign shifted    = shift_q >> OUT_WIDTH;
`endif

  assign last_chunk = (cnt_q == LAST_IDX);
  assign xfer       = (state_q == SEND) && ready_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!vacia_i) begin
          pop     = 1'b1;
          shift_d = dato_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (xfer) begin
          if (!last_chunk) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (!vacia_i) begin
            // Back-to-back: pop the next word on the edge that retires the
            // last chunk of the current one.
            pop     = 1'b1;
            shift_d = dato_i;
            cnt_d   = '0;
          end else begin
            // Clear leftovers so the register idles at zero.
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The pop strobe is combinational from vacia_i in IDLE; gating it with the
  // reset keeps it low while the block is held in reset even if the buffer
  // reports data.
  assign delecion_o  = pop && rstn_i;
  assign valid_o     = (state_q == SEND);
  assign dato_o      = valid_o ? head_chunk : '0;
  assign ultimo_o    = valid_o && last_chunk;
  assign ocupado_o   = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_buffer_drain_serializer.sv
// -----------------------------------------------------------------------------
// Bench for buffer_drain_serializer.
// The circular buffer is modelled as a queue of words; dato_i/vacia_i show its
// head and a word is removed after an edge on which delecion_o was high. Every
// word written into the buffer model also pushes its expected chunks (with the
// last-chunk flag) into exp_q; a separate monitor pops and compares on every
// valid/ready transfer and watches handshake rules each cycle.
// -----------------------------------------------------------------------------
module tb_buffer_drain_serializer;

  localparam int W  = 64;
  localparam int OW = 16;
  localparam int NC = W / OW;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          vacia_i;
  logic [W-1:0]  dato_i;
  logic          delecion_o;
  logic          valid_o;
  logic [OW-1:0] dato_o;
  logic          ready_i;
  logic          ultimo_o;
  logic          ocupado_o;
  logic          dbg_state_o;

  buffer_drain_serializer #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .vacia_i     (vacia_i),
    .dato_i      (dato_i),
    .delecion_o  (delecion_o),
    .valid_o     (valid_o),
    .dato_o      (dato_o),
    .ready_i     (ready_i),
    .ultimo_o    (ultimo_o),
    .ocupado_o   (ocupado_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Shared state
  // ---------------------------------------------------------------------------
  logic [W-1:0]  buf_q[$];     // buffer contents, head at index 0
  logic [OW:0]   exp_q[$];     // {last, chunk} in expected order
  int            n_total = 0;
  int            n_pass  = 0;
  int            ready_ctl = 1; // 0: hold low, 1: always high, 2: random
  bit            pop_pending = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference chunking: chunk i of a word, in transmission order.
  function automatic logic [OW-1:0] chunk_of(input logic [W-1:0] w, input int i);
`ifdef SERIAL_MSB_FIRST_EN
    chunk_of = OW'(w >> (W - (i + 1) * OW));
`else
    chunk_of = OW'(w >> (i * OW));
`endif
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    buf_q.push_back(w);
    for (int i = 0; i < NC; i++) exp_q.push_back({(i == NC - 1), chunk_of(w, i)});
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one cycle. Inputs change at the falling edge; returns 1 time unit
  // later with outputs settled for checking.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk_i);
    if (pop_pending && buf_q.size() > 0) buf_q.delete(0);
    vacia_i = (buf_q.size() == 0);
    dato_i  = vacia_i ? {$urandom, $urandom} : buf_q[0];
    case (ready_ctl)
      0:       ready_i = 1'b0;
      1:       ready_i = 1'b1;
      default: ready_i = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    pop_pending = rstn_i && delecion_o;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < budget) begin
      step();
      n++;
    end
    check({name, " drained"}, W'(exp_q.size()), W'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_dato;
  logic [OW:0]   exp_e;

  always begin
    @(negedge clk_i);
    #2;
    if (!rstn_i) begin
      prev_stall = 1'b0;
    end else begin
      if (delecion_o && vacia_i) check("pop_while_empty", W'(delecion_o), W'(0));
      if (prev_stall) begin
        check("stall_valid_held", W'(valid_o), W'(1));
        check("stall_data_held", W'(dato_o), W'(prev_dato));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_chunk", W'({ultimo_o, dato_o}), W'(0));
        end else begin
          exp_e = exp_q.pop_front();
          check("chunk", W'({ultimo_o, dato_o}), W'(exp_e));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_dato  = dato_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] word_a;
  logic [W-1:0] word_b;
  int           drop;

  initial begin
    rstn_i  = 1'b0;
    vacia_i = 1'b1;
    dato_i  = '0;
    ready_i = 1'b1;
    word_a  = 64'h1111_2222_3333_4444;
    word_b  = 64'hAAAA_BBBB_CCCC_DDDD;

    // Reset values
    #3;
    check("rst delecion", W'(delecion_o), W'(0));
    check("rst valid",    W'(valid_o),    W'(0));
    check("rst dato",     W'(dato_o),     W'(0));
    check("rst ultimo",   W'(ultimo_o),   W'(0));
    check("rst ocupado",  W'(ocupado_o),  W'(0));
    check("rst state",    W'(dbg_state_o), W'(0));
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;

    // Empty buffer: nothing happens
    for (int c = 0; c < 10; c++) begin
      step();
      check("empty delecion", W'(delecion_o), W'(0));
      check("empty valid",    W'(valid_o),    W'(0));
      check("empty ocupado",  W'(ocupado_o),  W'(0));
      check("empty dato",     W'(dato_o),     W'(0));
    end

    // Single word, sink always ready
    ready_ctl = 1;
    push_word(word_a);
    step();
    check("w1 pop",        W'(delecion_o), W'(1));
    check("w1 c0 valid",   W'(valid_o),    W'(0));
    for (int i = 0; i < NC; i++) begin
      step();
      check("w1 valid",    W'(valid_o),    W'(1));
      check("w1 dato",     W'(dato_o),     W'(chunk_of(word_a, i)));
      check("w1 ultimo",   W'(ultimo_o),   W'(i == NC - 1));
      check("w1 no pop",   W'(delecion_o), W'(0));
    end
    step();
    check("w1 end valid",   W'(valid_o),   W'(0));
    check("w1 end ocupado", W'(ocupado_o), W'(0));
    drain("w1", 20);

    // Two words queued: no bubble, pops on cycles 0 and NC only
    push_word(word_b);
    push_word(64'h0123_4567_89AB_CDEF);
    for (int c = 0; c <= 2 * NC + 1; c++) begin
      step();
      check("w2 valid", W'(valid_o),    W'(c >= 1 && c <= 2 * NC));
      check("w2 pop",   W'(delecion_o), W'(c == 0 || c == NC));
    end
    check("w2 ocupado end", W'(ocupado_o), W'(0));
    drain("w2", 20);

    // Backpressure on chunk 2
    push_word(word_a);
    repeat (3) step();                      // pop, chunk 0, chunk 1
    ready_ctl = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp valid",  W'(valid_o),    W'(1));
      check("bp dato",   W'(dato_o),     W'(chunk_of(word_a, 2)));
      check("bp no pop", W'(delecion_o), W'(0));
    end
    ready_ctl = 1;
    step();
    check("bp resume dato", W'(dato_o), W'(chunk_of(word_a, 2)));
    step();
    check("bp last dato",   W'(dato_o),   W'(chunk_of(word_a, 3)));
    check("bp last ultimo", W'(ultimo_o), W'(1));
    drain("bp", 20);

    // Reset in the middle of a word
    push_word(word_a);
    repeat (3) step();                      // pop, chunk 0, chunk 1 shown
    @(posedge clk_i);                       // chunk 1 accepted here
    #1;
    rstn_i = 1'b0;
    #1;
    check("mid rst valid",   W'(valid_o),   W'(0));
    check("mid rst dato",    W'(dato_o),    W'(0));
    check("mid rst ocupado", W'(ocupado_o), W'(0));
    check("mid rst ultimo",  W'(ultimo_o),  W'(0));
    // The in-flight word is discarded: drop whatever of it is still expected.
    drop = exp_q.size() - NC * buf_q.size();
    for (int i = 0; i < drop; i++) void'(exp_q.pop_front());
    pop_pending = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    push_word(word_b);
    step();
    check("post rst pop",   W'(delecion_o), W'(1));
    step();
    check("post rst dato0", W'(dato_o), W'(chunk_of(word_b, 0)));
    drain("post rst", 20);

    // Randomized traffic
    ready_ctl = 2;
    for (int c = 0; c < 500; c++) begin
      if (buf_q.size() < 3 && $urandom_range(0, 2) == 0) push_word({$urandom, $urandom});
      step();
    end
    ready_ctl = 1;
    drain("random", 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/buffer_drain_serializer.md
Name: buffer_drain_serializer

Overview:
- Consumer at the read end of the circular buffer.
- Pops WIDTH-bit words from the buffer via its empty flag, head-data output and delete strobe.
- Streams each word downstream as NUM_CHUNKS = WIDTH/OUT_WIDTH narrow chunks over a valid/ready handshake.
- Sits between the buffer and a narrow downstream sink; removes the bubble between consecutive words.

Parameters:
- WIDTH, 64, width of a buffer entry; must equal the buffer's WIDTH.
- OUT_WIDTH, 16, width of one output chunk; WIDTH % OUT_WIDTH == 0 is required (elaboration error otherwise).
- NUM_CHUNKS (localparam), WIDTH/OUT_WIDTH, chunks per word; chunk counter width is max(1, $clog2(NUM_CHUNKS)).

Ports:
- clk_i  input  1  clock, rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- vacia_i  input  1  buffer empty flag.
- dato_i  input  WIDTH  buffer head data, combinational from buffer, valid when vacia_i=0.
- delecion_o  output  1  one-cycle pop strobe to buffer; the word on dato_i is consumed at this edge.
- valid_o  output  1  chunk valid to sink.
- dato_o  output  OUT_WIDTH  current chunk.
- ready_i  input  1  sink ready; a transfer occurs on a cycle where valid_o=1 and ready_i=1.
- ultimo_o  output  1  high with valid_o on the final chunk of a word.
- ocupado_o  output  1  high when the FSM is not IDLE.

Behaviour:
- Reset (rstn_i=0, asynchronous): state=IDLE, shift register=0, chunk counter=0. Outputs: delecion_o=0, valid_o=0, dato_o=0, ultimo_o=0, ocupado_o=0.
- FSM states: IDLE, SEND.
- IDLE:
  - delecion_o = !vacia_i (combinational).
  - On the same edge, capture dato_i into the shift register, set counter=0 and go to SEND.
  - If vacia_i=1, stay in IDLE.
- SEND:
  - valid_o=1; dato_o = shift register bits [OUT_WIDTH-1:0].
  - ultimo_o = (counter == NUM_CHUNKS-1).
- Transfer, not last chunk: shift register right by OUT_WIDTH (zero fill); counter+1; stay in SEND.
- Transfer, last chunk, vacia_i=0:
  - delecion_o=1 in this cycle.
  - Load dato_i; counter=0; stay in SEND.
  - No idle cycle between words.
- Transfer, last chunk, vacia_i=1: go to IDLE; valid_o drops next cycle.
- No transfer (ready_i=0): hold shift register, counter and dato_o stable. valid_o must not drop once asserted until the transfer completes.
- delecion_o is asserted only in the two cases above:
  - never while vacia_i=1;
  - never more than once per word;
  - never in SEND except on the last-chunk transfer.
- Latency: first chunk is on dato_o 1 cycle after the pop edge. A word takes a minimum of NUM_CHUNKS cycles at ready_i=1.
- Words are popped from the head only, so order matches buffer order.
- A word that was popped but not fully sent when reset asserts is discarded, not re-read.
- The buffer drives llena_o high during reset; this block ignores it.
- NUM_CHUNKS=1: every chunk is last; ultimo_o=valid_o.
- Counter wraps only through reload to 0; it never exceeds NUM_CHUNKS-1.

Optional Feature:
- Macro: SERIAL_MSB_FIRST_EN.
- Defined:
  - chunks go most-significant first;
  - dato_o = shift register [WIDTH-1:WIDTH-OUT_WIDTH];
  - shift left by OUT_WIDTH with zero fill.
- Undefined (default): least-significant chunk first, as described above.
- Handshake, timing and ultimo_o are identical in both builds.

Test Plan:
- Reset, then vacia_i=1 for 10 cycles -> delecion_o=0, valid_o=0, ocupado_o=0 throughout; dato_o=0.
- One word 0x1111_2222_3333_4444, ready_i=1 -> delecion_o pulses 1 cycle; dato_o = 0x4444, 0x3333, 0x2222, 0x1111 on 4 consecutive cycles; ultimo_o only on 0x1111. With SERIAL_MSB_FIRST_EN the order is 0x1111, 0x2222, 0x3333, 0x4444.
- Two words queued (0xAAAA_BBBB_CCCC_DDDD, 0x0123_4567_89AB_CDEF), ready_i=1 -> 8 consecutive valid cycles with no gap; delecion_o high in cycle 0 and cycle 4 only.
- Backpressure: ready_i=0 for 3 cycles on chunk 2 of the first word -> dato_o holds 0x2222 with valid_o=1; no delecion_o; transfer resumes when ready_i=1.
- Buffer empties mid-stream: one word, ready_i=1 -> after ultimo_o, valid_o=0 and ocupado_o=0 on the next cycle; delecion_o never asserted while vacia_i=1.
- Reset mid-word: rstn_i=0 after chunk 1 of 0x1111_2222_3333_4444 -> outputs 0 immediately (asynchronous). After release, a new word streams from its chunk 0; the interrupted word is never re-sent.
